piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out transmit register for the registers lab.
//   Accepts an N-bit word over a valid/ready handshake and shifts it out one bit per clk.
//   It qualifies each bit with sout_valid and pulses done after the last bit.
//   It is the transmit end of the serial link; the matching deserializer receives the same bit order.
// PARAMETERS
//   N          8   word width in bits; legal range N >= 1
//   LSB_FIRST  1   1: bit 0 is sent first; 0: bit N-1 is sent first
// PORTS
//   clk         in   1  single clock; all state updates on posedge clk
//   reset       in   1  synchronous, active-high; highest priority
//   clear       in   1  synchronous, active-high abort; priority below reset, above load
//   din         in   N  parallel word, sampled only on the accept edge
//   load_valid  in   1  producer has a word on din
//   load_ready  out  1  block can accept a word this cycle
//   sout        out  1  serial data; forced 0 when sout_valid=0
//   sout_valid  out  1  sout carries a data bit this cycle
//   busy        out  1  high while in SHIFT
//   done        out  1  one-cycle pulse in the cycle after the last bit
// BEHAVIOUR
//   Reset and clear
//   - Values on reset: state=IDLE, shreg=0, cnt=0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
//   - clear gives the same next state as reset and discards any word in flight; no done pulse.
//   FSM states: IDLE, SHIFT, DONE. load_ready = (state==IDLE || state==DONE).
//   Accept
//   - Accept = load_valid && load_ready at posedge.
//   - On accept: shreg<=din, cnt<=0, state<=SHIFT.
//   - The first bit appears on sout in the cycle after the accept edge (latency 1).
//   SHIFT
//   - sout_valid=1, busy=1.
//   - sout = LSB_FIRST ? shreg[0] : shreg[N-1].
//   - Each edge: shift shreg toward the output end with zero fill, cnt<=cnt+1.
//   - When cnt==N-1 at an edge: state<=DONE.
//   - SHIFT lasts exactly N cycles; N=1 gives one SHIFT cycle.
//   DONE
//   - done=1, sout_valid=0, busy=0.
//   - On accept: go to SHIFT with the new word (back-to-back gap of exactly one idle bit).
//   - Otherwise go to IDLE.
//   - Word period is N+1 cycles.
//   Ignored input: load_valid during SHIFT (load_ready=0), and din outside the accept edge.
//   Counter
//   - cnt width CW = (N>1) ? $clog2(N) : 1.
//   - cnt never wraps, because the terminal compare is at N-1.
//   Simultaneous events
//   - reset with any other input: reset wins.
//   - clear with load_valid in IDLE: no accept, outputs stay at reset values.
//   Outputs: all outputs are decoded from registered state/shreg only; no path from inputs to outputs.
// STRUCTURE
//   - Shared header piso_defs.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
//     The deserializer includes the same header.
//   - Sub-module shift_reg_n: N-bit register with sync reset, load, and shift-enable.
//     Its direction is set by the LSB_FIRST parameter.
//   - The top level holds the FSM, the counter and the output decode.
// TESTING (N=8 unless noted; cycle k = k-th posedge after accept)
//   1. LSB_FIRST=1, din=8'h1E accepted.
//      -> sout = 0,1,1,1,1,0,0,0 in cycles 1..8 with sout_valid=1.
//      -> cycle 9: done=1, sout_valid=0.
//      -> cycle 10: IDLE, load_ready=1.
//   2. LSB_FIRST=0, din=8'h1E.
//      -> sout = 0,0,0,1,1,1,1,0.
//      -> done in cycle 9.
//   3. In SHIFT, load_valid=1 with din=8'hFF for cycles 2..5.
//      -> load_ready=0 and the 8'h1E sequence is unchanged.
//   4. reset=1 (or clear=1) for one edge in cycle 4.
//      -> next cycle: sout_valid=0, busy=0, done=0, load_ready=1, no done pulse.
//      -> a new 8'hA5 then transmits correctly.
//   5. Back-to-back: 8'h1E, then 8'h81 held valid.
//      -> 8'h81 accepted on the DONE cycle.
//      -> exactly one sout_valid=0 cycle between words.
//      -> second word sends 1,0,0,0,0,0,0,1.
//   6. N=1, din=1'b1.
//      -> sout_valid=1, sout=1 for one cycle, then done=1 for one cycle.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encodings and sizing helper for the PISO serializer
package piso_serializer_pkg;

    // These encodings are shared with the matching deserializer.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_shift_reg.sv
// rtl/piso_serializer_shift_reg.sv - N-bit load/shift register with zero fill toward the output end
module shift_reg_n
    import piso_serializer_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o,
    output logic         out_bit_o
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (shift_i) begin
            q_d = LSB_FIRST ? (q_q >> 1) : (q_q << 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o       = q_q;
    assign out_bit_o = LSB_FIRST ? q_q[0] : q_q[N-1];

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with valid/ready load and done pulse
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [N-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [N-1:0]  shreg;
    logic          out_bit;
    logic          accept;
    logic          in_shift;
    logic          sync_rst;

    assign sync_rst   = reset || clear;
    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept     = load_valid && load_ready;
    assign in_shift   = (state_q == ST_SHIFT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // Hold the counter on the last bit so it never wraps.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    shift_reg_n #(
        .N         (N),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .rst_i     (sync_rst),
        .load_i    (accept),
        .shift_i   (in_shift),
        .d_i       (din),
        .q_o       (shreg),
        .out_bit_o (out_bit)
    );

    assign sout_valid = in_shift;
    assign sout       = in_shift && out_bit;
    assign busy       = in_shift;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed vector bench for piso_serializer (N=8 both orders, N=1)
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset, clear, load_valid;
    logic [7:0] din;
    logic       a_ready, a_sout, a_valid, a_busy, a_done;
    logic       b_ready, b_sout, b_valid, b_busy, b_done;
    logic       c_load_valid;
    logic [0:0] c_din;
    logic       c_ready, c_sout, c_valid, c_busy, c_done;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    piso_serializer #(.N(8), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .load_valid(load_valid),
        .load_ready(a_ready), .sout(a_sout), .sout_valid(a_valid), .busy(a_busy), .done(a_done));

    piso_serializer #(.N(8), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .load_valid(load_valid),
        .load_ready(b_ready), .sout(b_sout), .sout_valid(b_valid), .busy(b_busy), .done(b_done));

    piso_serializer #(.N(1), .LSB_FIRST(1'b1)) dut_c (
        .clk(clk), .reset(reset), .clear(clear), .din(c_din), .load_valid(c_load_valid),
        .load_ready(c_ready), .sout(c_sout), .sout_valid(c_valid), .busy(c_busy), .done(c_done));

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        bit         noise;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s actual=%0h required=%0h", tag, name, act, exp);
        end
    endtask

    task automatic accept(input logic [7:0] d);
        din        = d;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        din        = ~d;
    endtask

    // exp bit k is the sout value in cycle k+1 after the accept edge
    task automatic shift_check(input string tag, input logic [7:0] ea, input logic [7:0] eb, input bit noise);
        for (int k = 0; k < 8; k++) begin
            chk(tag, "a_sout", 32'(a_sout), 32'(ea[k]));
            chk(tag, "b_sout", 32'(b_sout), 32'(eb[k]));
            chk(tag, "a_valid", 32'(a_valid), 32'd1);
            chk(tag, "b_valid", 32'(b_valid), 32'd1);
            chk(tag, "a_busy", 32'(a_busy), 32'd1);
            chk(tag, "a_ready", 32'(a_ready), 32'd0);
            chk(tag, "a_done", 32'(a_done), 32'd0);
            if (noise) begin
                load_valid = (k >= 1 && k <= 4);
                din        = 8'hFF;
            end
            tick();
        end
    endtask

    task automatic done_check(input string tag);
        chk(tag, "done_a", 32'(a_done), 32'd1);
        chk(tag, "done_b", 32'(b_done), 32'd1);
        chk(tag, "done_valid", 32'(a_valid), 32'd0);
        chk(tag, "done_sout", 32'(a_sout), 32'd0);
        chk(tag, "done_busy", 32'(a_busy), 32'd0);
        chk(tag, "done_ready", 32'(a_ready), 32'd1);
        tick();
        chk(tag, "idle_done", 32'(a_done), 32'd0);
        chk(tag, "idle_ready", 32'(a_ready), 32'd1);
        chk(tag, "idle_valid", 32'(b_valid), 32'd0);
    endtask

    task automatic abort_test(input string tag, input bit use_clear);
        int seen_done;
        accept(8'h1E);
        tick();
        tick();
        tick();
        reset = !use_clear;
        clear = use_clear;
        tick();
        reset = 1'b0;
        clear = 1'b0;
        chk(tag, "abort_valid", 32'(a_valid), 32'd0);
        chk(tag, "abort_busy", 32'(a_busy), 32'd0);
        chk(tag, "abort_done", 32'(a_done), 32'd0);
        chk(tag, "abort_ready", 32'(a_ready), 32'd1);
        chk(tag, "abort_sout", 32'(b_sout), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_done || b_done || a_valid) seen_done++;
            tick();
        end
        chk(tag, "abort_quiet", 32'(seen_done), 32'd0);
        accept(8'hA5);
        shift_check(tag, 8'hA5, 8'hA5, 1'b0);
        done_check(tag);
    endtask

    initial begin
        vecs[0] = '{din: 8'h1E, exp_a: 8'h1E, exp_b: 8'h78, noise: 1'b0};
        vecs[1] = '{din: 8'h1E, exp_a: 8'h1E, exp_b: 8'h78, noise: 1'b1};
        vecs[2] = '{din: 8'hA5, exp_a: 8'hA5, exp_b: 8'hA5, noise: 1'b0};
        vecs[3] = '{din: 8'hC1, exp_a: 8'hC1, exp_b: 8'h83, noise: 1'b1};
        vecs[4] = '{din: 8'h01, exp_a: 8'h01, exp_b: 8'h80, noise: 1'b0};
        vecs[5] = '{din: 8'h00, exp_a: 8'h00, exp_b: 8'h00, noise: 1'b0};

        reset        = 1'b1;
        clear        = 1'b0;
        load_valid   = 1'b0;
        din          = 8'h00;
        c_load_valid = 1'b0;
        c_din        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset", "a_ready", 32'(a_ready), 32'd1);
        chk("reset", "a_valid", 32'(a_valid), 32'd0);
        chk("reset", "a_sout", 32'(a_sout), 32'd0);
        chk("reset", "a_busy", 32'(a_busy), 32'd0);
        chk("reset", "a_done", 32'(a_done), 32'd0);
        chk("reset", "c_ready", 32'(c_ready), 32'd1);
        tick();

        for (int v = 0; v < 6; v++) begin
            accept(vecs[v].din);
            shift_check($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b, vecs[v].noise);
            load_valid = 1'b0;
            done_check($sformatf("vec%0d", v));
        end

        abort_test("reset_abort", 1'b0);
        abort_test("clear_abort", 1'b1);

        // clear together with load_valid in IDLE must not accept
        clear      = 1'b1;
        load_valid = 1'b1;
        din        = 8'hFF;
        tick();
        clear      = 1'b0;
        load_valid = 1'b0;
        chk("clr_idle", "valid", 32'(a_valid), 32'd0);
        chk("clr_idle", "busy", 32'(a_busy), 32'd0);
        chk("clr_idle", "ready", 32'(a_ready), 32'd1);
        tick();

        // back-to-back: second word held valid through the first transmission
        din        = 8'h1E;
        load_valid = 1'b1;
        tick();
        din = 8'h81;
        shift_check("b2b_w0", 8'h1E, 8'h78, 1'b0);
        chk("b2b", "gap_valid", 32'(a_valid), 32'd0);
        chk("b2b", "gap_done", 32'(a_done), 32'd1);
        chk("b2b", "gap_ready", 32'(a_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        shift_check("b2b_w1", 8'h81, 8'h81, 1'b0);
        done_check("b2b_w1");

        // N=1 instance
        c_din        = 1'b1;
        c_load_valid = 1'b1;
        tick();
        c_load_valid = 1'b0;
        c_din        = 1'b0;
        chk("n1", "valid", 32'(c_valid), 32'd1);
        chk("n1", "sout", 32'(c_sout), 32'd1);
        chk("n1", "busy", 32'(c_busy), 32'd1);
        chk("n1", "ready", 32'(c_ready), 32'd0);
        tick();
        chk("n1", "done", 32'(c_done), 32'd1);
        chk("n1", "done_valid", 32'(c_valid), 32'd0);
        tick();
        chk("n1", "idle_done", 32'(c_done), 32'd0);
        chk("n1", "idle_ready", 32'(c_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
